perf_window_ctrl: RTL and testbench
===================================

Name: perf_window_ctrl

Overview:
- Controller for the pipeline performance counters: start/stop/clear commands bound a measurement window.
- Captures free-running cycle and retired-instruction counts at window open and close, and presents the modular deltas through a done/rd_ack handshake.
- Sits between the debug/CSR command path and the performance counter block; drives that block's clear strobe.

Parameters:
CNT_W, 32, width of counter inputs, deltas and window length

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-low reset
cmd_valid  input  1  command strobe
cmd_op  input  2  01 START, 10 STOP, 11 CLEAR, 00 NOP
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
win_len  input  CNT_W  window length in cycles; 0 = unbounded; sampled at START acceptance
trig_en  input  1  START waits for trig; sampled at START acceptance
trig  input  1  external window-open trigger
cycle_count  input  CNT_W  free-running cycle count from counter block
inst_count  input  CNT_W  retired-instruction count from counter block
perf_clr  output  1  one-cycle clear strobe to counter block
busy  output  1  state is ARM or RUN
done  output  1  result valid; held until rd_ack
win_expired  output  1  with done: window ended by win_len, not STOP
rd_ack  input  1  consumer has read the result
cycle_delta  output  CNT_W  end minus base cycle_count
inst_delta  output  CNT_W  end minus base inst_count

Behaviour:
- Reset (rst==0 at posedge):
  - state IDLE; all outputs 0 except cmd_ready=1.
  - Internal base, win_cnt and latched win_len cleared.
  - Reset mid-window aborts the window with no done.
- All outputs are registered.
- cmd_ready = 1 in every state except CLR.
- States: IDLE, ARM, RUN, DONE, CLR.
- IDLE/DONE + START:
  - Latch win_len and trig_en.
  - If trig_en=1: go to ARM.
  - Else: go to RUN, capturing base_cyc/base_inst from the inputs at that edge; win_cnt=0.
  - START in DONE clears done and win_expired; START wins over a same-cycle rd_ack.
- ARM:
  - trig=1 at an edge: capture base, win_cnt=0, go to RUN.
  - STOP: go to IDLE, no done.
  - START: ignored (cmd still accepted).
- RUN, each edge:
  - STOP: capture end, go to DONE, win_expired=0.
  - Else if latched win_len!=0 and win_cnt==win_len-1: capture end, go to DONE, win_expired=1.
  - Else win_cnt++.
  - RUN therefore occupies exactly win_len cycles, so a free-running cycle_count yields cycle_delta==win_len.
  - STOP on the same edge as expiry: the STOP path applies, win_expired=0.
  - START in RUN: ignored.
- End capture:
  - cycle_delta = cycle_count - base_cyc, mod 2^CNT_W; inst_delta likewise.
  - Wrap of either input counter gives the correct modular delta.
  - inst_delta may be smaller than expected if the counter block decremented on flush; no saturation.
  - done=1 from the next cycle.
- DONE:
  - rd_ack=1: go to IDLE; done and win_expired drop the next cycle; deltas hold their values.
  - STOP: ignored.
- CLEAR (any state):
  - Go to CLR.
  - In CLR (one cycle): perf_clr=1, cmd_ready=0, done=0, win_expired=0, deltas=0, busy=0.
  - Then go to IDLE.
  - CLEAR overrides same-cycle expiry and rd_ack.
- rd_ack outside DONE: ignored.
- win_cnt width CNT_W.
  - win_len==1 gives a one-cycle RUN.
  - win_len==0 is never compared, so the window ends only on STOP or CLEAR.

Test Plan:
- Timed window: rst, START with trig_en=0, win_len=10, cycle_count free-running from 0x100, inst_count +1 every other cycle -> busy for 10 cycles, then done=1, win_expired=1, cycle_delta=10, inst_delta=5; rd_ack -> done=0 next cycle.
- Triggered open and early STOP: START with trig_en=1, win_len=0; trig pulsed 4 cycles later; STOP 7 cycles after RUN entry -> ARM lasts 4 cycles, cycle_delta=7, win_expired=0.
- Wrap: base cycle_count=0xFFFFFFFC, win_len=8 -> cycle_delta=8.
- CLEAR mid-RUN: CLEAR accepted -> next cycle perf_clr=1, cmd_ready=0, busy=0, deltas=0; following cycle IDLE, cmd_ready=1; no done ever.
- Simultaneous events:
  - STOP on the expiry edge -> win_expired=0.
  - START and rd_ack together in DONE -> new window starts, done=0.
  - STOP in ARM -> IDLE, no done.
- Reset mid-operation: rst low while RUN with win_len=20 -> next cycle all outputs 0, cmd_ready=1; START afterwards behaves as after power-on.

Source files
------------

// File: rtl/perf_window_ctrl.sv
// perf_window_ctrl: start/stop/clear window control for the perf counters.
// Snapshots cycle/instret at window open and close, reports modular deltas.
module perf_window_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] win_len,
  input  logic             trig_en,
  input  logic             trig,
  input  logic [CNT_W-1:0] cycle_count,
  input  logic [CNT_W-1:0] inst_count,
  output logic             perf_clr,
  output logic             busy,
  output logic             done,
  output logic             win_expired,
  input  logic             rd_ack,
  output logic [CNT_W-1:0] cycle_delta,
  output logic [CNT_W-1:0] inst_delta
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    DONE,
    CLR
  } state_t;

  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] base_cyc;
  logic [CNT_W-1:0] base_inst;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] len_q;

  logic acc;
  logic start;
  logic stop;
  logic clear;
  logic expire;

  assign acc    = cmd_valid & cmd_ready;
  assign start  = acc & (cmd_op == OP_START);
  assign stop   = acc & (cmd_op == OP_STOP);
  assign clear  = acc & (cmd_op == OP_CLEAR);
  // A zero length means unbounded, so it never matches.
  assign expire = (len_q != '0) &&
                  (win_cnt == len_q - ONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      perf_clr    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      win_expired <= 1'b0;
      cycle_delta <= '0;
      inst_delta  <= '0;
      base_cyc    <= '0;
      base_inst   <= '0;
      win_cnt     <= '0;
      len_q       <= '0;
    end else begin
      cmd_ready <= 1'b1;
      perf_clr  <= 1'b0;
      if (clear) begin
        state       <= CLR;
        cmd_ready   <= 1'b0;
        perf_clr    <= 1'b1;
        busy        <= 1'b0;
        done        <= 1'b0;
        win_expired <= 1'b0;
        cycle_delta <= '0;
        inst_delta  <= '0;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            if (start) begin
              len_q       <= win_len;
              busy        <= 1'b1;
              done        <= 1'b0;
              win_expired <= 1'b0;
              if (trig_en) begin
                state <= ARM;
              end else begin
                base_cyc  <= cycle_count;
                base_inst <= inst_count;
                win_cnt   <= '0;
                state     <= RUN;
              end
            end else if (state == DONE && rd_ack) begin
              state       <= IDLE;
              done        <= 1'b0;
              win_expired <= 1'b0;
            end
          end
          ARM: begin
            if (stop) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (trig) begin
              base_cyc  <= cycle_count;
              base_inst <= inst_count;
              win_cnt   <= '0;
              state     <= RUN;
            end
          end
          RUN: begin
            if (stop || expire) begin
              cycle_delta <= cycle_count - base_cyc;
              inst_delta  <= inst_count - base_inst;
              done        <= 1'b1;
              win_expired <= ~stop;
              busy        <= 1'b0;
              state       <= DONE;
            end else begin
              win_cnt <= win_cnt + ONE;
            end
          end
          CLR: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_perf_window_ctrl.sv
// tb_perf_window_ctrl: vector table, corner sequences and random traffic
// checked against a window-level reference model.
module tb_perf_window_ctrl;

  localparam int W = 32;
  localparam logic [1:0] NOP   = 2'b00;
  localparam logic [1:0] START = 2'b01;
  localparam logic [1:0] STOP  = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  localparam int P_IDLE = 0;
  localparam int P_ARM  = 1;
  localparam int P_RUN  = 2;
  localparam int P_DONE = 3;
  localparam int P_CLR  = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic [1:0]   cmd_op;
  logic         cmd_ready;
  logic [W-1:0] win_len;
  logic         trig_en;
  logic         trig;
  logic [W-1:0] cycle_count;
  logic [W-1:0] inst_count;
  logic         perf_clr;
  logic         busy;
  logic         done;
  logic         win_expired;
  logic         rd_ack;
  logic [W-1:0] cycle_delta;
  logic [W-1:0] inst_delta;

  always #5 clk = ~clk;

  perf_window_ctrl #(.CNT_W(W)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_op(cmd_op),
    .cmd_ready(cmd_ready),
    .win_len(win_len),
    .trig_en(trig_en),
    .trig(trig),
    .cycle_count(cycle_count),
    .inst_count(inst_count),
    .perf_clr(perf_clr),
    .busy(busy),
    .done(done),
    .win_expired(win_expired),
    .rd_ack(rd_ack),
    .cycle_delta(cycle_delta),
    .inst_delta(inst_delta)
  );

  typedef struct {
    logic         rn;
    logic         va;
    logic [1:0]   op;
    logic [W-1:0] len;
    logic         te;
    logic         tg;
    logic         ak;
    logic [4:0]   ctl;
    logic [W-1:0] cd;
    logic [W-1:0] id;
  } vec_t;

  vec_t tbl[$];
  int   n_run = 0;
  int   n_fail = 0;
  bit   rand_inst = 1'b0;

  // Reference model: phase, snapshots and elapsed RUN edges.
  int           m_ph = P_IDLE;
  logic [W-1:0] m_bc = '0;
  logic [W-1:0] m_bi = '0;
  logic [W-1:0] m_len = '0;
  logic [W-1:0] m_el = '0;
  logic         m_ready = 1'b1;
  logic         m_clr = 1'b0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic         m_exp = 1'b0;
  logic [W-1:0] m_cd = '0;
  logic [W-1:0] m_id = '0;

  function automatic vec_t v(
    input logic rn, va, input logic [1:0] op,
    input logic [W-1:0] len, input logic te, tg, ak,
    input logic [4:0] ctl, input logic [W-1:0] cd, id);
    vec_t r;
    r.rn = rn; r.va = va; r.op = op; r.len = len;
    r.te = te; r.tg = tg; r.ak = ak;
    r.ctl = ctl; r.cd = cd; r.id = id;
    return r;
  endfunction

  task automatic model_step(
    input logic rn, va, input logic [1:0] op,
    input logic [W-1:0] ln, input logic te, tg, ak,
    input logic [W-1:0] cc, ic);
    logic acc;
    acc = va && m_ready;
    if (!rn) begin
      m_ph = P_IDLE; m_ready = 1'b1; m_clr = 1'b0;
      m_busy = 1'b0; m_done = 1'b0; m_exp = 1'b0;
      m_cd = '0; m_id = '0; m_len = '0; m_el = '0;
      m_bc = '0; m_bi = '0;
    end else if (acc && op == CLEAR) begin
      m_ph = P_CLR; m_ready = 1'b0; m_clr = 1'b1;
      m_busy = 1'b0; m_done = 1'b0; m_exp = 1'b0;
      m_cd = '0; m_id = '0;
    end else begin
      m_ready = 1'b1;
      m_clr = 1'b0;
      if (m_ph == P_IDLE || m_ph == P_DONE) begin
        if (acc && op == START) begin
          m_len = ln; m_busy = 1'b1;
          m_done = 1'b0; m_exp = 1'b0;
          if (te) begin
            m_ph = P_ARM;
          end else begin
            m_bc = cc; m_bi = ic; m_el = '0; m_ph = P_RUN;
          end
        end else if (m_ph == P_DONE && ak) begin
          m_ph = P_IDLE; m_done = 1'b0; m_exp = 1'b0;
        end
      end else if (m_ph == P_ARM) begin
        if (acc && op == STOP) begin
          m_ph = P_IDLE; m_busy = 1'b0;
        end else if (tg) begin
          m_bc = cc; m_bi = ic; m_el = '0; m_ph = P_RUN;
        end
      end else if (m_ph == P_RUN) begin
        m_el = m_el + 1;
        if ((acc && op == STOP) ||
            (m_len != 0 && m_el == m_len)) begin
          m_exp = !(acc && op == STOP);
          m_cd = cc - m_bc; m_id = ic - m_bi;
          m_done = 1'b1; m_busy = 1'b0; m_ph = P_DONE;
        end
      end else begin
        m_ph = P_IDLE;
      end
    end
  endtask

  task automatic step();
    logic rn, va, te, tg, ak;
    logic [1:0] op;
    logic [W-1:0] ln, cc, ic;
    logic [68:0] got, want;
    rn = rst; va = cmd_valid; op = cmd_op; ln = win_len;
    te = trig_en; tg = trig; ak = rd_ack;
    cc = cycle_count; ic = inst_count;
    @(posedge clk);
    model_step(rn, va, op, ln, te, tg, ak, cc, ic);
    #1;
    cycle_count = cycle_count + 1;
    if (!rand_inst) begin
      if (cycle_count[0]) inst_count = inst_count + 1;
    end else begin
      case ($urandom % 8)
        0: inst_count = inst_count - 1;
        1, 2, 3: inst_count = inst_count;
        7: inst_count = inst_count + 2;
        default: inst_count = inst_count + 1;
      endcase
    end
    got = {cmd_ready, perf_clr, busy, done, win_expired,
           cycle_delta, inst_delta};
    want = {m_ready, m_clr, m_busy, m_done, m_exp, m_cd, m_id};
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL model t=%0t: got %h want %h", $time, got, want);
    end
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Expected control word is {ready, clr, busy, done, expired}.
  task automatic ctl(input string nm, input logic [4:0] e);
    chk(nm, {27'b0, cmd_ready, perf_clr, busy, done, win_expired},
        {27'b0, e});
  endtask

  task automatic go(input logic [1:0] op, input logic tg, ak);
    cmd_valid = (op != NOP);
    cmd_op = op;
    trig = tg;
    rd_ack = ak;
    step();
    cmd_valid = 1'b0;
    cmd_op = NOP;
    trig = 1'b0;
    rd_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = NOP; win_len = '0;
    trig_en = 1'b0; trig = 1'b0; rd_ack = 1'b0;
    cycle_count = 32'h100; inst_count = '0;

    // Timed window of 10, cycle from 0x100, instret every other cycle.
    tbl.push_back(v(0, 0, NOP, 0, 0, 0, 0, 5'b10000, 0, 0));
    tbl.push_back(v(1, 1, START, 10, 0, 0, 0, 5'b10100, 0, 0));
    for (int i = 0; i < 9; i++)
      tbl.push_back(v(1, 0, NOP, 0, 0, 0, 0, 5'b10100, 0, 0));
    tbl.push_back(v(1, 0, NOP, 0, 0, 0, 0, 5'b10011, 10, 5));
    tbl.push_back(v(1, 0, NOP, 0, 0, 0, 0, 5'b10011, 10, 5));
    tbl.push_back(v(1, 0, NOP, 0, 0, 0, 1, 5'b10000, 10, 5));
    tbl.push_back(v(1, 0, NOP, 0, 0, 0, 0, 5'b10000, 10, 5));
    // STOP on the expiry edge of a 3-cycle window.
    tbl.push_back(v(1, 1, START, 3, 0, 0, 0, 5'b10100, 10, 5));
    tbl.push_back(v(1, 0, NOP, 7, 0, 0, 0, 5'b10100, 10, 5));
    tbl.push_back(v(1, 0, NOP, 7, 0, 0, 0, 5'b10100, 10, 5));
    tbl.push_back(v(1, 1, STOP, 7, 0, 0, 0, 5'b10010, 3, 1));
    // START together with rd_ack in DONE.
    tbl.push_back(v(1, 1, START, 2, 0, 0, 1, 5'b10100, 3, 1));
    tbl.push_back(v(1, 0, NOP, 0, 0, 0, 0, 5'b10100, 3, 1));
    tbl.push_back(v(1, 0, NOP, 0, 0, 0, 0, 5'b10011, 2, 1));
    tbl.push_back(v(1, 0, NOP, 0, 0, 0, 1, 5'b10000, 2, 1));
    // One-cycle window, STOP ignored in DONE, rd_ack ignored in IDLE.
    tbl.push_back(v(1, 1, START, 1, 0, 0, 0, 5'b10100, 2, 1));
    tbl.push_back(v(1, 0, NOP, 0, 0, 0, 0, 5'b10011, 1, 0));
    tbl.push_back(v(1, 1, STOP, 0, 0, 0, 0, 5'b10011, 1, 0));
    tbl.push_back(v(1, 0, NOP, 0, 0, 0, 1, 5'b10000, 1, 0));
    tbl.push_back(v(1, 0, NOP, 0, 0, 0, 1, 5'b10000, 1, 0));

    foreach (tbl[i]) begin
      rst = tbl[i].rn; cmd_valid = tbl[i].va; cmd_op = tbl[i].op;
      win_len = tbl[i].len; trig_en = tbl[i].te;
      trig = tbl[i].tg; rd_ack = tbl[i].ak;
      step();
      ctl($sformatf("row%0d ctl", i), tbl[i].ctl);
      chk($sformatf("row%0d cyc", i), cycle_delta, tbl[i].cd);
      chk($sformatf("row%0d inst", i), inst_delta, tbl[i].id);
    end
    cmd_valid = 1'b0; cmd_op = NOP; trig = 1'b0; rd_ack = 1'b0;

    // Triggered open, START ignored in ARM and RUN, STOP after 7.
    trig_en = 1'b1; win_len = 0;
    go(START, 0, 0); ctl("arm_enter", 5'b10100);
    win_len = 5;
    go(START, 0, 0); ctl("arm_start_ign", 5'b10100);
    go(NOP, 0, 0); ctl("arm_wait2", 5'b10100);
    go(NOP, 0, 0); ctl("arm_wait3", 5'b10100);
    go(NOP, 1, 0); ctl("trig_run", 5'b10100);
    go(START, 0, 0); ctl("run_start_ign", 5'b10100);
    for (int i = 0; i < 5; i++) go(NOP, 0, 0);
    ctl("run_unbounded", 5'b10100);
    go(STOP, 0, 0); ctl("trig_stop", 5'b10010);
    chk("trig_stop cyc", cycle_delta, 7);
    go(NOP, 0, 1); ctl("trig_ack", 5'b10000);

    // Cycle counter wraps inside the window.
    trig_en = 1'b0; win_len = 8; cycle_count = 32'hFFFF_FFFC;
    go(START, 0, 0);
    for (int i = 0; i < 7; i++) go(NOP, 0, 0);
    ctl("wrap_busy", 5'b10100);
    go(NOP, 0, 0); ctl("wrap_done", 5'b10011);
    chk("wrap cyc", cycle_delta, 8);
    go(NOP, 0, 1);

    // STOP while armed.
    trig_en = 1'b1;
    go(START, 0, 0); ctl("arm2", 5'b10100);
    go(STOP, 0, 0); ctl("arm_stop", 5'b10000);
    go(NOP, 0, 0); ctl("arm_stop_idle", 5'b10000);
    chk("arm_stop hold", cycle_delta, 8);

    // CLEAR mid-RUN, START during CLR is not accepted.
    trig_en = 1'b0; win_len = 0;
    go(START, 0, 0);
    for (int i = 0; i < 3; i++) go(NOP, 0, 0);
    go(CLEAR, 0, 0); ctl("clr_cycle", 5'b01000);
    chk("clr cyc", cycle_delta, 0);
    chk("clr inst", inst_delta, 0);
    go(START, 0, 0); ctl("clr_idle", 5'b10000);
    for (int i = 0; i < 3; i++) go(NOP, 0, 0);
    ctl("clr_no_done", 5'b10000);

    // CLEAR beats a same-edge expiry.
    win_len = 2;
    go(START, 0, 0);
    go(NOP, 0, 0);
    go(CLEAR, 0, 0); ctl("clr_vs_exp", 5'b01000);
    go(NOP, 0, 0); ctl("clr_vs_exp_idle", 5'b10000);

    // Reset in the middle of a 20-cycle window.
    go(START, 0, 0); go(NOP, 0, 0); go(NOP, 0, 0);
    chk("pre_rst cyc", cycle_delta, 2);
    go(NOP, 0, 1);
    win_len = 20;
    go(START, 0, 0);
    for (int i = 0; i < 5; i++) go(NOP, 0, 0);
    rst = 1'b0;
    go(NOP, 0, 0);
    rst = 1'b1;
    ctl("rst_mid", 5'b10000);
    chk("rst cyc", cycle_delta, 0);
    chk("rst inst", inst_delta, 0);
    win_len = 3;
    go(START, 0, 0); ctl("post_rst_run", 5'b10100);
    go(NOP, 0, 0); go(NOP, 0, 0);
    go(NOP, 0, 0); ctl("post_rst_done", 5'b10011);
    chk("post_rst cyc", cycle_delta, 3);
    go(NOP, 0, 1);

    // Random traffic against the model, crossing a counter wrap.
    rand_inst = 1'b1;
    cycle_count = 32'hFFFF_FA00;
    inst_count = 32'hFFFF_FF00;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 150) != 0;
      cmd_valid = ($urandom % 4) == 0;
      cmd_op = 2'($urandom);
      win_len = W'($urandom % 10);
      trig_en = 1'($urandom);
      trig = ($urandom % 5) == 0;
      rd_ack = ($urandom % 3) == 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
